// File: rtl/ser_tx.sv
// Parallel-to-serial frame transmitter: start(0), DATA_W data bits LSB first, optional parity, stop(1).
// Define SER_TX_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module ser_tx #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  localparam int BITW = $clog2(DATA_W + 1);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(DATA_W - 1);

`ifdef SER_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state, state_d;
  logic [DATA_W-1:0]   shift, shift_d;
  logic [BITW-1:0]     bitcnt, bitcnt_d;
  logic [DIVW-1:0]     divcnt, divcnt_d;
  logic                sout_d;
  logic                done_d;
  logic                bit_end;
`ifdef SER_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  assign bit_end = (divcnt == DIV_LAST);

  // sout is registered alongside the state so the line is glitch-free at the far end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      shift  <= '0;
      bitcnt <= '0;
      divcnt <= '0;
      sout   <= 1'b1;
      done   <= 1'b0;
`ifdef SER_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      shift  <= shift_d;
      bitcnt <= bitcnt_d;
      divcnt <= divcnt_d;
      sout   <= sout_d;
      done   <= done_d;
`ifdef SER_TX_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state;
    shift_d  = shift;
    bitcnt_d = bitcnt;
    divcnt_d = divcnt;
    done_d   = 1'b0;
`ifdef SER_TX_PARITY_EN
    par_d    = par_q;
`endif
    if (state != IDLE) begin
      divcnt_d = bit_end ? '0 : divcnt + 1'b1;
    end
    case (state)
      IDLE: begin
        if (din_valid) begin
          state_d  = START;
          shift_d  = din;
          bitcnt_d = '0;
          divcnt_d = '0;
`ifdef SER_TX_PARITY_EN
          par_d    = ^din;
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift >> 1;
          if (bitcnt == BIT_LAST) begin
            bitcnt_d = '0;
`ifdef SER_TX_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = STOP;
`endif
          end else begin
            bitcnt_d = bitcnt + 1'b1;
          end
        end
      end
`ifdef SER_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line value is looked up from the state being entered, so it changes on the same edge.
  always_comb begin
    din_ready = (state == IDLE);
    busy      = (state != IDLE);
    sout_d    = 1'b1;
    case (state_d)
      START:   sout_d = 1'b0;
      DATA:    sout_d = shift_d[0];
`ifdef SER_TX_PARITY_EN
      PARITY:  sout_d = par_d;
`endif
      default: sout_d = 1'b1;
    endcase
  end

endmodule
